// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters with a valid/ready response path.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module alu_share_arbiter #(
    parameter int MUL_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, ctl_q, ctl_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        zero_q, zero_d, err_q, err_d;
    logic        owner_q, owner_d, last_q, last_d;
    logic        v0_q, v0_d, v1_q, v1_d;
    logic        idle, tie_pick1, gnt0, gnt1;
    logic [3:0]  sel_op;
    logic [31:0] sel_a, sel_b;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    assign tie_pick1 = ~last_q;
`else
    assign tie_pick1 = 1'b0;
`endif

    assign idle   = state_q == IDLE;
    assign gnt1   = idle & req1_valid & (~req0_valid | tie_pick1);
    assign gnt0   = idle & req0_valid & ~gnt1;
    assign sel_op = gnt1 ? req1_op : req0_op;
    assign sel_a  = gnt1 ? req1_a : req0_a;
    assign sel_b  = gnt1 ? req1_b : req0_b;

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign rsp0_valid  = v0_q;
    assign rsp1_valid  = v1_q;
    assign rsp_result  = res_q;
    assign rsp_zero    = zero_q;
    assign rsp_err     = err_q;
    assign alu_control = ctl_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign busy        = ~idle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        owner_d = owner_q;
        last_d  = last_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        case (state_q)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    owner_d = gnt1;
                    if (sel_op == 4'd8) begin
                        // Rejected opcode never reaches the ALU.
                        state_d = RESP;
                        res_d   = '0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        v0_d    = ~gnt1;
                        v1_d    = gnt1;
                    end else begin
                        state_d = EXEC;
                        ctl_d   = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        cnt_d   = (sel_op == 4'd9) ? 4'(MUL_WAIT) : 4'd0;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    res_d   = alu_result;
                    zero_d  = alu_zero;
                    err_d   = 1'b0;
                    v0_d    = ~owner_q;
                    v1_d    = owner_q;
                end
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                    v0_d    = 1'b0;
                    v1_d    = 1'b0;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
        end
    end
endmodule
